// File: rtl/fifo784_rd_ctrl.sv
// Frame read sequencer: drains one IMG_W x IMG_H frame from the CNN input FIFO onto a
// tagged valid/ready pixel stream. Define FIFO784_RDCTRL_UFCHK_EN to enable underflow checking.
module fifo784_rd_ctrl #(
    parameter int unsigned W      = 32,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                     rclk,
    input  logic                     rrst,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     fifo_re,
    input  logic [W-1:0]             fifo_dout,
    input  logic                     fifo_rempty,
    input  logic                     fifo_underflow,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [W-1:0]             m_data,
    output logic [$clog2(IMG_H)-1:0] m_row,
    output logic [$clog2(IMG_W)-1:0] m_col,
    output logic                     m_sof,
    output logic                     m_eol,
    output logic                     m_eof,
    output logic                     err
);

    localparam int unsigned FN  = IMG_W * IMG_H;
    localparam int unsigned D   = RD_LAT + 1;
    localparam int unsigned NW  = $clog2(FN + 1);
    localparam int unsigned RW  = $clog2(IMG_H);
    localparam int unsigned CLW = $clog2(IMG_W);
    localparam int unsigned PW  = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned CW  = $clog2(D + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [NW-1:0]     issued;
    logic [NW-1:0]     accepted;
    logic [W-1:0]      mem [D];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     occ;
    logic [RD_LAT-1:0] pipe;
    logic              pop;
    logic              push;
    logic              uf_hit;
    logic              kill;

`ifdef FIFO784_RDCTRL_UFCHK_EN
    assign uf_hit = busy && fifo_underflow;

    always_ff @(posedge rclk) begin
        if (rrst)
            err <= 1'b0;
        else if (uf_hit)
            err <= 1'b1;
    end
`else
    logic unused_uf;
    assign unused_uf = fifo_underflow;
    assign uf_hit    = 1'b0;
    assign err       = 1'b0;
`endif

    assign kill    = abort || uf_hit;
    assign busy    = (state == RUN) || (state == DRAIN);
    assign done    = (state == DONE);
    assign m_valid = (cnt != '0);
    assign m_data  = mem[rd_ptr];
    assign m_sof   = m_valid && (accepted == '0);
    assign m_eol   = m_valid && (m_col == CLW'(IMG_W - 1));
    assign m_eof   = m_valid && (accepted == NW'(FN - 1));
    assign pop     = m_valid && m_ready;
    assign push    = pipe[RD_LAT-1];

    // Credit counts reads still in the latency pipe so a returning word always finds a slot.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++)
            inflight = inflight + CW'(pipe[i]);
        occ     = cnt + inflight;
        fifo_re = (state == RUN) && !fifo_rempty && (issued < NW'(FN))
                  && ((occ - CW'(pop)) < CW'(D));
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state    <= IDLE;
            issued   <= '0;
            accepted <= '0;
            m_row    <= '0;
            m_col    <= '0;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pipe     <= '0;
            for (int unsigned i = 0; i < D; i++)
                mem[i] <= '0;
        end else begin
            pipe <= RD_LAT'({pipe, fifo_re});
            if (fifo_re)
                issued <= issued + NW'(1);

            if (push) begin
                mem[wr_ptr] <= fifo_dout;
                wr_ptr      <= (wr_ptr == PW'(D - 1)) ? '0 : wr_ptr + PW'(1);
            end

            if (pop) begin
                rd_ptr   <= (rd_ptr == PW'(D - 1)) ? '0 : rd_ptr + PW'(1);
                accepted <= accepted + NW'(1);
                if (m_col == CLW'(IMG_W - 1)) begin
                    m_col <= '0;
                    m_row <= (m_row == RW'(IMG_H - 1)) ? '0 : m_row + RW'(1);
                end else begin
                    m_col <= m_col + CLW'(1);
                end
            end

            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);

            case (state)
                IDLE: if (start && !kill) begin
                    state    <= RUN;
                    issued   <= '0;
                    accepted <= '0;
                    m_row    <= '0;
                    m_col    <= '0;
                end
                RUN: begin
                    if (pop && accepted == NW'(FN - 1))
                        state <= DONE;
                    else if (issued == NW'(FN))
                        state <= DRAIN;
                end
                DRAIN: if (pop && accepted == NW'(FN - 1))
                    state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Abort overrides everything above: late FIFO data in the pipe is discarded.
            if (kill && state != IDLE) begin
                state  <= IDLE;
                pipe   <= '0;
                cnt    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo784_rd_ctrl.sv
// Bench for fifo784_rd_ctrl: behavioural FIFO model, per-beat reference expectations
// derived from the frame geometry, table-driven frame scenarios plus abort/reset/underflow sequences.
module tb_fifo784_rd_ctrl;

    parameter int unsigned RD_LAT = 1;
    localparam int unsigned W     = 32;
    localparam int unsigned IMG_W = 28;
    localparam int unsigned IMG_H = 28;
    localparam int unsigned FN    = IMG_W * IMG_H;
    localparam int unsigned D     = RD_LAT + 1;
    localparam int unsigned NV    = 4;

    logic rclk = 1'b0;
    logic rrst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic fifo_underflow = 1'b0;
    logic m_ready;
    logic fifo_rempty = 1'b1;
    logic busy, done, fifo_re, m_valid, m_sof, m_eol, m_eof, err;
    logic [W-1:0] fifo_dout, m_data;
    logic [$clog2(IMG_H)-1:0] m_row;
    logic [$clog2(IMG_W)-1:0] m_col;

    fifo784_rd_ctrl #(.W(W), .IMG_W(IMG_W), .IMG_H(IMG_H), .RD_LAT(RD_LAT)) dut (
        .rclk(rclk), .rrst(rrst), .start(start), .abort(abort),
        .busy(busy), .done(done), .fifo_re(fifo_re), .fifo_dout(fifo_dout),
        .fifo_rempty(fifo_rempty), .fifo_underflow(fifo_underflow),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
        .m_col(m_col), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .err(err)
    );

    always #5 rclk = ~rclk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO model (fixed read latency) ----------------
    logic [W-1:0] fq [$];
    logic [W-1:0] src [$];
    logic [W-1:0] lat_q [RD_LAT];
    bit           paced = 1'b0;
    int unsigned  pace_cnt = 0;

    assign fifo_dout = lat_q[RD_LAT-1];

    always @(posedge rclk) begin
        logic [W-1:0] w;
        w = 32'hBAD0_0000;
        if (fifo_re === 1'b1 && fq.size() != 0) w = fq.pop_front();
        lat_q[0] <= w;
        for (int i = 1; i < RD_LAT; i++) lat_q[i] <= lat_q[i-1];
        pace_cnt++;
        if (src.size() != 0 && (!paced || pace_cnt % 3 == 0)) begin
            if (paced) fq.push_back(src.pop_front());
            else while (src.size() != 0) fq.push_back(src.pop_front());
        end
        fifo_rempty <= (fq.size() == 0);
    end

    // ---------------- downstream ready pattern ----------------
    int unsigned rdy_mode = 0;
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge rclk); #1;
            m_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stream monitor / reference ----------------
    int unsigned frame_id = 0;
    int unsigned base = 0;
    int unsigned seen_id = 0;
    int unsigned cyc = 0, beat = 0, done_cnt = 0, done_cyc = 0;
    int unsigned first_cyc = 0, last_cyc = 0, n_re = 0, n_pop = 0, max_occ = 0, viol = 0;
    logic        held = 1'b0;
    logic [63:0] held_snap = '0;

    always @(negedge rclk) begin
        logic [63:0] snap, exp;
        cyc++;
        if (frame_id != seen_id) begin
            seen_id = frame_id; beat = 0; done_cnt = 0; n_re = 0; n_pop = 0;
            max_occ = 0; viol = 0; held = 1'b0;
        end
        if (n_re - n_pop > max_occ) max_occ = n_re - n_pop;
        if (fifo_re === 1'b1 && fifo_rempty) viol++;
        snap = {7'b0, m_valid, m_data, 8'(m_row), 8'(m_col), 5'b0, m_sof, m_eol, m_eof};
        if (held) check("hold", snap, held_snap);
        if (m_valid && m_ready) begin
            exp = {7'b0, 1'b1, 32'(base + beat), 8'(beat / IMG_W), 8'(beat % IMG_W), 5'b0,
                   1'(beat == 0), 1'((beat % IMG_W) == IMG_W - 1), 1'(beat == FN - 1)};
            check("beat", snap, exp);
            if (beat == 0) first_cyc = cyc;
            last_cyc = cyc;
            beat++;
            n_pop++;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (fifo_re === 1'b1) n_re++;
        held = m_valid && !m_ready;
        held_snap = snap;
    end

    // ---------------- helpers ----------------
    int unsigned next_word = 0;

    task automatic tick(input int unsigned n);
        repeat (n) begin @(posedge rclk); #1; end
    endtask

    task automatic load(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            src.push_back(next_word);
            next_word++;
        end
    endtask

    task automatic wait_beats(input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (beat < n && k < budget) begin tick(1); k++; end
        check("wait_beats", 64'(beat >= n), 64'd1);
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned k = 0;
        while (done_cnt == 0 && k < budget) begin tick(1); k++; end
        check("wait_done", 64'(done_cnt != 0), 64'd1);
    endtask

    task automatic check_idle(input string name);
        check(name, {8'(busy), 8'(done), 8'(fifo_re), 8'(m_valid), 8'(m_sof), 8'(m_eol),
                     8'(m_eof), 8'(err)}, 64'd0);
        check({name, "_dat"}, {m_data, 8'(m_row), 8'(m_col)}, 64'd0);
    endtask

    typedef struct {
        int unsigned rdy_mode;
        bit          paced;
        int unsigned exp_lat;
        bit          exp_b2b;
        int unsigned exp_beats;
        int unsigned exp_done;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        int unsigned k;
        vecs[0] = '{rdy_mode: 0, paced: 0, exp_lat: RD_LAT + 2, exp_b2b: 1, exp_beats: FN, exp_done: 1};
        vecs[1] = '{rdy_mode: 1, paced: 0, exp_lat: 0, exp_b2b: 0, exp_beats: FN, exp_done: 1};
        vecs[2] = '{rdy_mode: 0, paced: 1, exp_lat: 0, exp_b2b: 0, exp_beats: FN, exp_done: 1};
        vecs[3] = '{rdy_mode: 1, paced: 1, exp_lat: 0, exp_b2b: 0, exp_beats: FN, exp_done: 1};

        tick(3);
        check_idle("reset");
        rrst = 1'b0;
        tick(2);

        for (int v = 0; v < NV; v++) begin
            paced = vecs[v].paced;
            rdy_mode = vecs[v].rdy_mode;
            base = next_word;
            load(FN);
            frame_id++;
            tick(4);
            start = 1'b1;
            tick(1);
            start = 1'b0;
            if (vecs[v].exp_lat != 0) begin
                check("start_busy", 64'(busy), 64'd1);
                check("start_re", 64'(fifo_re), 64'd1);
                k = 1;
                while (!m_valid && k < 20) begin tick(1); k++; end
                check("first_lat", 64'(k), 64'(vecs[v].exp_lat));
            end
            wait_done(20000);
            tick(3);
            check("beats", 64'(beat), 64'(vecs[v].exp_beats));
            check("done_cnt", 64'(done_cnt), 64'(vecs[v].exp_done));
            check("done_after_eof", 64'(done_cyc), 64'(last_cyc + 1));
            check("occ_le_D", 64'(max_occ <= D), 64'd1);
            check("re_while_empty", 64'(viol), 64'd0);
            check("idle_after", 64'(busy), 64'd0);
            if (vecs[v].exp_b2b) check("back_to_back", 64'(last_cyc - first_cyc), 64'(FN - 1));
        end

        // abort mid-frame with reads in flight
        paced = 1'b0;
        rdy_mode = 0;
        base = next_word;
        load(2 * FN);
        frame_id++;
        tick(3);
        start = 1'b1; tick(1); start = 1'b0;
        wait_beats(100, 2000);
        abort = 1'b1; tick(1); abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(m_valid), 64'd0);
        tick(10);
        check("abort_no_done", 64'(done_cnt), 64'd0);

        // restart picks up the next unread word; start mid-frame ignored; reset mid-frame
        base = fq[0];
        frame_id++;
        start = 1'b1; tick(1); start = 1'b0;
        wait_beats(1, 50);
        wait_beats(50, 500);
        start = 1'b1; tick(1); start = 1'b0;
        check("start_ignored", 64'(busy), 64'd1);
        wait_beats(300, 1000);
        rrst = 1'b1;
        tick(2);
        check_idle("midframe_reset");
        rrst = 1'b0;
        check("reset_no_done", 64'(done_cnt), 64'd0);
        fq.delete();
        src.delete();
        tick(3);

        // underflow injection
        base = next_word;
        load(FN);
        frame_id++;
        tick(3);
        start = 1'b1; tick(1); start = 1'b0;
        wait_beats(10, 100);
        fifo_underflow = 1'b1; tick(1); fifo_underflow = 1'b0;
`ifdef FIFO784_RDCTRL_UFCHK_EN
        check("uf_err", 64'(err), 64'd1);
        check("uf_idle", 64'(busy), 64'd0);
        tick(5);
        check("uf_err_sticky", 64'(err), 64'd1);
        check("uf_no_done", 64'(done_cnt), 64'd0);
`else
        check("uf_err", 64'(err), 64'd0);
        check("uf_continue", 64'(busy), 64'd1);
        wait_done(4000);
        tick(2);
        check("uf_beats", 64'(beat), 64'(FN));
        check("uf_done", 64'(done_cnt), 64'd1);
        check("uf_err_end", 64'(err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
